// File: rtl/input_conditioner_pkg.sv
// Shared types and constants for the push-button / slide-switch input conditioner.
// Default cycle counts assume the 50 MHz system clock.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_STABLE   = 2'd1,
    ST_CHANGING = 2'd2
  } ch_state_e;

  localparam int unsigned CLK_HZ               = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES  = 1_000_000;    // 20 ms
  localparam int unsigned DEF_LONGPRESS_CYCLES = 100_000_000;  // 2 s

  // Counter width for a terminal count of n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_DB_CNT_W   = cnt_width(DEF_DEBOUNCE_CYCLES);
  localparam int unsigned DEF_HOLD_CNT_W = cnt_width(DEF_LONGPRESS_CYCLES);

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input bit: 2-flop synchroniser, INIT/STABLE/CHANGING debounce FSM,
// and single-cycle rise/fall pulses aligned with the first cycle db shows the new level.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic ready
);

  localparam int unsigned   CW            = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST      = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_INIT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic meta_q, s_q, s_prev_q;

  ch_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= RST_VAL;
      s_q      <= RST_VAL;
      s_prev_q <= RST_VAL;
    end else begin
      meta_q   <= raw;
      s_q      <= meta_q;
      s_prev_q <= s_q;
    end
  end

  // INIT counts equalities between successive samples, so the load happens when the
  // D-th identical sample is seen (the reset value of s_prev counts as the first one).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (s_q != s_prev_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_INIT_LAST) begin
          db_d    = s_q;
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STABLE: begin
        if (s_q != db_q) begin
          cnt_d   = CW'(1);
          state_d = ST_CHANGING;
        end else begin
          cnt_d = '0;
        end
      end
      ST_CHANGING: begin
        if (s_q == db_q) begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          db_d    = s_q;
          rise_d  = s_q;
          fall_d  = ~s_q;
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      db_q    <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db    = db_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign ready = (state_q != ST_INIT);

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw key (active-low) and switch pins into debounced levels plus
// press/release/long-press/change pulses for the PIO inputs and wallet confirm logic.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned N_KEY            = 2,
  parameter int unsigned N_SW             = 4,
  parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONGPRESS_CYCLES = DEF_LONGPRESS_CYCLES
) (
  input  logic             clk_clk,
  input  logic             reset_n_reset_n,
  input  logic [N_KEY-1:0] key_n_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_KEY-1:0] key_n_db,
  output logic [N_SW-1:0]  sw_db,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic [N_KEY-1:0] key_long,
  output logic [N_SW-1:0]  sw_change,
  output logic             init_done
);

  localparam int unsigned   HW        = cnt_width(LONGPRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONGPRESS_CYCLES - 1);

  logic [N_KEY-1:0] key_ready;
  logic [N_SW-1:0]  sw_ready;
  logic [N_SW-1:0]  sw_rise;
  logic [N_SW-1:0]  sw_fall;
  logic             init_done_q, init_done_d;

  generate
    for (genvar gi = 0; gi < N_KEY; gi++) begin : g_key
      logic [HW-1:0] hold_q, hold_d;
      logic          long_done_q, long_done_d;
      logic          long_hit;

      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (1'b1)
      ) u_chan (
        .clk  (clk_clk),
        .rst_n(reset_n_reset_n),
        .raw  (key_n_raw[gi]),
        .db   (key_n_db[gi]),
        .rise (key_release[gi]),
        .fall (key_press[gi]),
        .ready(key_ready[gi])
      );

      // hold_q is 0 in the key_press cycle because the level was released the cycle before.
      // long_done_q blocks repeats and also suppresses a long press for a level loaded at INIT.
      assign long_hit = ~key_n_db[gi] & (hold_q == HOLD_LAST) & ~long_done_q;

      always_comb begin
        hold_d      = hold_q;
        long_done_d = long_done_q | long_hit;
        if (!key_ready[gi]) begin
          hold_d      = '0;
          long_done_d = 1'b1;
        end else if (key_n_db[gi]) begin
          hold_d      = '0;
          long_done_d = 1'b0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end

      always_ff @(posedge clk_clk or negedge reset_n_reset_n) begin
        if (!reset_n_reset_n) begin
          hold_q      <= '0;
          long_done_q <= 1'b0;
        end else begin
          hold_q      <= hold_d;
          long_done_q <= long_done_d;
        end
      end

      assign key_long[gi] = long_hit;
    end

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (1'b0)
      ) u_chan (
        .clk  (clk_clk),
        .rst_n(reset_n_reset_n),
        .raw  (sw_raw[gi]),
        .db   (sw_db[gi]),
        .rise (sw_rise[gi]),
        .fall (sw_fall[gi]),
        .ready(sw_ready[gi])
      );
    end
  endgenerate

  assign sw_change = sw_rise | sw_fall;

  always_comb begin
    init_done_d = init_done_q | ((&key_ready) && (&sw_ready));
  end

  always_ff @(posedge clk_clk or negedge reset_n_reset_n) begin
    if (!reset_n_reset_n) begin
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= init_done_d;
    end
  end

  assign init_done = init_done_q;

endmodule
